mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: port 0 is the multicycle CPU datapath (instruction fetch and lb/sb) and port 1 is the program loader/debug master.
- Each requester uses a req/ack handshake. The arbiter latches the request, drives the memory for exactly one cycle, waits out the read latency and then returns an ack pulse with the read data.
- The CPU controller treats a missing ack as a stall in its fetch and memory states.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory data width.
- RD_LATENCY, 1, cycles from the issue edge to valid mem_rdata_i. Legal range is 1 to 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  2  per-port request level; bit n is port n.
- we_i  in  2  per-port write enable (1 = write).
- addr0_i / addr1_i  in  ADDR_WIDTH  per-port address.
- wdata0_i / wdata1_i  in  DATA_WIDTH  per-port write data.
- ack_o  out  2  one-cycle completion pulse, one-hot.
- rdata_o  out  DATA_WIDTH  read data, valid while ack_o is nonzero for a read.
- busy_o  out  1  high whenever state is not IDLE.
- owner_o  out  1  index of the port owning the current transaction.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdata_i  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset (asynchronous, rst=0): all of the following clear immediately.
  - state=IDLE.
  - ack_o=0, mem_en_o=0, mem_we_o=0, busy_o=0, owner_o=0.
  - rdata_o=0, mem_addr_o=0, mem_wdata_o=0.
  - last_grant=1, so port 0 wins the first tie.
  - A transaction in flight is abandoned and no ack is issued for it.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_i bit is set, pick a winner and register owner, we, addr and wdata. Next state is ISSUE.
  - Only one bit set: that port wins.
  - Both bits set: the port other than last_grant wins (2-way round robin). last_grant updates to the winner.
- ISSUE: mem_en_o=1 for exactly this cycle, with mem_we_o/mem_addr_o/mem_wdata_o taken from the latched values.
  - Write: next state is DONE.
  - Read: next state is WAIT, with cnt=RD_LATENCY-1.
- WAIT:
  - cnt=0: capture mem_rdata_i into rdata_o and go to DONE.
  - Otherwise decrement cnt.
- DONE: ack_o[owner]=1 for exactly one cycle. Next state is IDLE.
- Latency from the first cycle req is seen in IDLE to ack:
  - Write: 2 cycles.
  - Read: RD_LATENCY+2 cycles, i.e. 3 at the default.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until it sees ack.
  - In the cycle after ack it must drop req or present a new request.
  - A req seen high in IDLE is always treated as a new transaction.
  - Changes to the non-owner's inputs during a transaction are ignored.
- rdata_o holds its value after ack until the next read capture. Writes do not alter rdata_o.
- A request arriving while busy waits. The arbiter never pre-empts and never queues more than the current transaction.
- Back-to-back streams from both ports alternate strictly, so no port can be starved.
- mem_en_o never asserts outside ISSUE. mem_addr_o and mem_wdata_o hold their last latched values when idle.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0_o and gnt_cnt1_o, each 16 bits.
  - Each counts completed transactions (DONE cycles) for its port and wraps modulo 2^16.
  - Both counters clear on reset.
- When undefined: these ports and their counters do not exist, and behaviour is otherwise identical.

Decomposition:
- defines.v gets the following constants:
  - MARB_STATE_WIDTH.
  - MARB_STATE_IDLE/ISSUE/WAIT/DONE.
  - MARB_PORT_CPU=0 and MARB_PORT_LDR=1.
- One sub-module, mem_arb_rr_pick: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: valid, winner.
- The FSM, latency counter and datapath latches stay in mem_port_arbiter.

Test Plan:
- Reset, then port 0 read from addr 0x10, with the memory model returning 0xDEADBEEF at RD_LATENCY=1:
  - mem_en_o pulses one cycle later with mem_we_o=0.
  - ack_o=01 arrives 3 cycles after req, with rdata_o=0xDEADBEEF.
- Port 1 write of 0x12345678 to addr 0x20:
  - mem_en_o=1, mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0x12345678 in the ISSUE cycle.
  - ack_o=10 two cycles after req.
  - rdata_o is unchanged.
- Both ports request continuously from reset:
  - Grants order as 0,1,0,1 and owner_o alternates.
  - Each ack_o is a single-cycle pulse.
- Port 1 requests while port 0's read is in WAIT with RD_LATENCY=3:
  - Port 0 acks at cycle 5.
  - Port 1 enters ISSUE only after the return to IDLE.
- rst driven low during WAIT:
  - All outputs drop to 0 asynchronously and no ack appears.
  - After release, a new port 1 request completes normally.
- With MEM_ARB_STATS_EN defined, issue 3 port-0 transactions and 2 port-1 transactions:
  - gnt_cnt0_o=3, gnt_cnt1_o=2.
  - Both clear to 0 on reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_port_arbiter_pkg;

  localparam int MARB_STATE_WIDTH = 2;

  typedef enum logic [MARB_STATE_WIDTH-1:0] {
    MARB_STATE_IDLE  = 2'd0,
    MARB_STATE_ISSUE = 2'd1,
    MARB_STATE_WAIT  = 2'd2,
    MARB_STATE_DONE  = 2'd3
  } marb_state_t;

  localparam logic MARB_PORT_CPU = 1'b0;
  localparam logic MARB_PORT_LDR = 1'b1;

  // Read latency is at most 4, so the countdown never needs more than 2 bits.
  localparam int MARB_CNT_WIDTH = 2;

  // Countdown start value loaded on leaving ISSUE for a read.
  function automatic logic [MARB_CNT_WIDTH-1:0] marb_wait_init(input int rd_latency);
    return MARB_CNT_WIDTH'(rd_latency - 1);
  endfunction

  // One-hot ack vector for a port index.
  function automatic logic [1:0] marb_onehot(input logic port);
    return (port == MARB_PORT_LDR) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// Latency: n/a (wires only).
// Backpressure: req held until ack; the arbiter side is the slave modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            req_i;
  logic [1:0]            we_i;
  logic [ADDR_WIDTH-1:0] addr0_i;
  logic [ADDR_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wdata0_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic [1:0]            ack_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  busy_o;
  logic                  owner_o;
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  // Arbiter view.
  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    output ack_o, rdata_o, busy_o, owner_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Requester plus memory view.
  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    input  ack_o, rdata_o, busy_o, owner_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker.
// Latency: 0 cycles.
// Backpressure: none; the caller only samples the result while idle.
module mem_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  // A lone requester wins outright; a tie goes to the port that lost last time.
  always_comb begin
    valid  = |req;
    winner = req[1];
    if (req == 2'b11) begin
      winner = ~last_grant;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync memory between CPU (port 0) and loader (port 1); MEM_ARB_STATS_EN adds grant counters.
// Latency: req seen in IDLE to ack is 2 cycles for writes, RD_LATENCY+2 for reads.
// Backpressure: one transaction at a time; other requests wait at the req level until the arbiter returns to IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] gnt_cnt0_o,
  output logic [15:0] gnt_cnt1_o
`endif
);

  marb_state_t               state;
  logic                      last_grant;
  logic                      cur_we;
  logic [MARB_CNT_WIDTH-1:0] cnt;
  logic                      pick_valid;
  logic                      pick_winner;

  mem_arb_rr_pick u_pick (
    .req        (bus.req_i),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Main FSM: latch the winner in IDLE, strobe memory in ISSUE, count out the
  // read latency in WAIT and pulse the owner's ack in DONE. All outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= MARB_STATE_IDLE;
      last_grant      <= MARB_PORT_LDR;
      cur_we          <= 1'b0;
      cnt             <= '0;
      bus.ack_o       <= 2'b00;
      bus.rdata_o     <= '0;
      bus.busy_o      <= 1'b0;
      bus.owner_o     <= MARB_PORT_CPU;
      bus.mem_en_o    <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      bus.ack_o    <= 2'b00;
      bus.mem_en_o <= 1'b0;
      bus.mem_we_o <= 1'b0;
      case (state)
        MARB_STATE_IDLE: begin
          if (pick_valid) begin
            last_grant      <= pick_winner;
            bus.owner_o     <= pick_winner;
            cur_we          <= bus.we_i[pick_winner];
            bus.mem_en_o    <= 1'b1;
            bus.mem_we_o    <= bus.we_i[pick_winner];
            bus.mem_addr_o  <= (pick_winner == MARB_PORT_LDR) ? bus.addr1_i : bus.addr0_i;
            bus.mem_wdata_o <= (pick_winner == MARB_PORT_LDR) ? bus.wdata1_i : bus.wdata0_i;
            bus.busy_o      <= 1'b1;
            state           <= MARB_STATE_ISSUE;
          end
        end
        MARB_STATE_ISSUE: begin
          if (cur_we) begin
            bus.ack_o <= marb_onehot(bus.owner_o);
            state     <= MARB_STATE_DONE;
          end else begin
            cnt   <= marb_wait_init(RD_LATENCY);
            state <= MARB_STATE_WAIT;
          end
        end
        MARB_STATE_WAIT: begin
          if (cnt == '0) begin
            bus.rdata_o <= bus.mem_rdata_i;
            bus.ack_o   <= marb_onehot(bus.owner_o);
            state       <= MARB_STATE_DONE;
          end else begin
            cnt <= cnt - MARB_CNT_WIDTH'(1);
          end
        end
        MARB_STATE_DONE: begin
          bus.busy_o <= 1'b0;
          state      <= MARB_STATE_IDLE;
        end
        default: begin
          bus.busy_o <= 1'b0;
          state      <= MARB_STATE_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Per-port completion counters, bumped once per DONE cycle and wrapping at 2^16.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_cnt0_o <= '0;
      gnt_cnt1_o <= '0;
    end else if (state == MARB_STATE_DONE) begin
      if (bus.owner_o == MARB_PORT_LDR) begin
        gnt_cnt1_o <= gnt_cnt1_o + 16'd1;
      end else begin
        gnt_cnt0_o <= gnt_cnt0_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (read latency 1 and 3) with memory models and scoreboards.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [1:0]  ack;
    logic        is_rd;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb1[$];
  exp_t sb3[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] c1_0, c1_1, c3_0, c3_1;
`endif

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
`ifdef MEM_ARB_STATS_EN
    , .gnt_cnt0_o(c1_0), .gnt_cnt1_o(c1_1)
`endif
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3)
`ifdef MEM_ARB_STATS_EN
    , .gnt_cnt0_o(c3_0), .gnt_cnt1_o(c3_1)
`endif
  );

  // Power-on memory contents.
  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {16'hC0DE, 8'h00, a};
  endfunction

  // Memory model for dut1: one-cycle read pipe, garbage when no read was issued.
  logic [31:0] m1 [256];
  bit          w1 [256];
  logic [31:0] p1_q;
  always @(posedge clk) begin
    if (if1.mem_en_o && if1.mem_we_o) begin
      m1[if1.mem_addr_o[7:0]] <= if1.mem_wdata_o;
      w1[if1.mem_addr_o[7:0]] <= 1'b1;
    end
    p1_q <= (if1.mem_en_o && !if1.mem_we_o)
          ? (w1[if1.mem_addr_o[7:0]] ? m1[if1.mem_addr_o[7:0]] : init_word(if1.mem_addr_o[7:0]))
          : 32'hBAD0_BAD0;
  end
  assign if1.mem_rdata_i = p1_q;

  // Memory model for dut3: read-only, three-stage read pipe.
  logic [31:0] p3_q [3];
  always @(posedge clk) begin
    p3_q[0] <= (if3.mem_en_o && !if3.mem_we_o) ? init_word(if3.mem_addr_o[7:0]) : 32'hBAD3_BAD3;
    p3_q[1] <= p3_q[0];
    p3_q[2] <= p3_q[1];
  end
  assign if3.mem_rdata_i = p3_q[2];

  // Bench-side reference of dut1 memory contents.
  logic [31:0] ref1 [256];
  bit          rw1  [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on dut1 through the scoreboard; checks the ISSUE cycle and latency.
  task automatic txn1(input string tag, input logic port, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
    exp_t        e;
    int          n;
    logic [31:0] keep;
    e.ack   = port ? 2'b10 : 2'b01;
    e.is_rd = !wr;
    e.rdata = rw1[addr[7:0]] ? ref1[addr[7:0]] : init_word(addr[7:0]);
    e.cyc   = exp_lat;
    if (wr) begin
      ref1[addr[7:0]] = wdata;
      rw1[addr[7:0]]  = 1'b1;
    end
    sb1.push_back(e);
    keep = if1.rdata_o;
    if (port) begin
      if1.addr1_i = addr; if1.wdata1_i = wdata;
    end else begin
      if1.addr0_i = addr; if1.wdata0_i = wdata;
    end
    if1.we_i[port]  = wr;
    if1.req_i[port] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        chk({tag, " issue en"}, 32'(if1.mem_en_o), 32'd1);
        chk({tag, " issue we"}, 32'(if1.mem_we_o), 32'(wr));
        chk({tag, " issue addr"}, if1.mem_addr_o, addr);
        if (wr) chk({tag, " issue wdata"}, if1.mem_wdata_o, wdata);
        chk({tag, " owner"}, 32'(if1.owner_o), 32'(port));
      end
    end while (if1.ack_o == 2'b00 && n < 20);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    e = sb1.pop_front();
    chk({tag, " ack"}, 32'(if1.ack_o), 32'(e.ack));
    chk({tag, " rdata"}, if1.rdata_o, e.is_rd ? e.rdata : keep);
    if1.req_i[port] = 1'b0;
    step();
    chk({tag, " ack drop"}, 32'(if1.ack_o), 32'd0);
    chk({tag, " idle busy"}, 32'(if1.busy_o), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   got;
    int   n;
    bit   prev;
    bit   en_seen;
    bit   saw_ack;

    if1.req_i = 2'b00; if1.we_i = 2'b00;
    if1.addr0_i = '0; if1.addr1_i = '0; if1.wdata0_i = '0; if1.wdata1_i = '0;
    if3.req_i = 2'b00; if3.we_i = 2'b00;
    if3.addr0_i = '0; if3.addr1_i = '0; if3.wdata0_i = '0; if3.wdata1_i = '0;

    // Reset state.
    step(); step();
    chk("rst ack", 32'(if1.ack_o), 32'd0);
    chk("rst mem_en", 32'(if1.mem_en_o), 32'd0);
    chk("rst mem_we", 32'(if1.mem_we_o), 32'd0);
    chk("rst busy", 32'(if1.busy_o), 32'd0);
    chk("rst owner", 32'(if1.owner_o), 32'd0);
    chk("rst rdata", if1.rdata_o, 32'd0);
    chk("rst mem_addr", if1.mem_addr_o, 32'd0);
    chk("rst mem_wdata", if1.mem_wdata_o, 32'd0);
    rst = 1'b1;
    step();

    // Single transactions, latency 1.
    txn1("p0 rd 10", 1'b0, 1'b0, 32'h10, 32'h0, 3);
    txn1("p1 wr 20", 1'b1, 1'b1, 32'h20, 32'h1234_5678, 2);
    txn1("p1 rd 20", 1'b1, 1'b0, 32'h20, 32'h0, 3);
    txn1("p0 wr 24", 1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, 2);
    txn1("p0 rd 24", 1'b0, 1'b0, 32'h24, 32'h0, 3);

    // Both ports requesting continuously from reset: strict alternation 0,1,0,1.
    rst = 1'b0;
    if1.we_i = 2'b00; if1.addr0_i = 32'h30; if1.addr1_i = 32'h40;
    if1.req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e.ack = k[0] ? 2'b10 : 2'b01;
      e.is_rd = 1'b1;
      e.rdata = k[0] ? init_word(8'h40) : init_word(8'h30);
      e.cyc = 0;
      sb1.push_back(e);
    end
    step();
    rst = 1'b1;
    got = 0;
    prev = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      step();
      if (prev) chk("rr ack pulse", 32'(if1.ack_o), 32'd0);
      prev = (if1.ack_o != 2'b00);
      if (prev) begin
        if (sb1.size() != 0) e = sb1.pop_front();
        else e.ack = 2'b00;
        chk("rr grant", 32'(if1.ack_o), 32'(e.ack));
        chk("rr rdata", if1.rdata_o, e.rdata);
        chk("rr owner", 32'(if1.owner_o), 32'(e.ack == 2'b10));
        got++;
        if (got == 4) if1.req_i = 2'b00;
      end
    end
    chk("rr count", 32'(got), 32'd4);
    step();
    chk("rr tail ack", 32'(if1.ack_o), 32'd0);
    sb1.delete();

    // Latency 3: port 1 arrives during port 0's WAIT and must wait for IDLE.
    if3.we_i = 2'b00; if3.addr0_i = 32'h50; if3.req_i = 2'b01;
    sb3.push_back('{ack: 2'b01, is_rd: 1'b1, rdata: init_word(8'h50), cyc: 5});
    sb3.push_back('{ack: 2'b10, is_rd: 1'b1, rdata: init_word(8'h60), cyc: 11});
    en_seen = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      step();
      if (t == 2) begin
        if3.addr1_i = 32'h60;
        if3.req_i[1] = 1'b1;
      end
      if (if3.mem_en_o && t > 1 && !en_seen) begin
        en_seen = 1'b1;
        chk("l3 p1 issue cycle", 32'(t), 32'd7);
        chk("l3 p1 issue addr", if3.mem_addr_o, 32'h60);
      end
      if (if3.ack_o != 2'b00) begin
        if (sb3.size() != 0) e = sb3.pop_front();
        else e = '{ack: 2'b00, is_rd: 1'b0, rdata: 32'h0, cyc: 0};
        chk("l3 ack", 32'(if3.ack_o), 32'(e.ack));
        chk("l3 rdata", if3.rdata_o, e.rdata);
        chk("l3 ack cycle", 32'(t), 32'(e.cyc));
        if (if3.ack_o[0]) if3.req_i[0] = 1'b0;
        if (if3.ack_o[1]) if3.req_i[1] = 1'b0;
      end
    end
    chk("l3 p1 issued", 32'(en_seen), 32'd1);
    chk("l3 sb drained", 32'(sb3.size()), 32'd0);
    if3.req_i = 2'b00;

    // Asynchronous reset in the middle of a latency-3 WAIT.
    if3.addr0_i = 32'h50; if3.req_i = 2'b01;
    step(); step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst busy", 32'(if3.busy_o), 32'd0);
    chk("arst owner", 32'(if3.owner_o), 32'd0);
    chk("arst rdata", if3.rdata_o, 32'd0);
    chk("arst mem_addr", if3.mem_addr_o, 32'd0);
    chk("arst ack", 32'(if3.ack_o), 32'd0);
    if3.req_i = 2'b00;
    saw_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (if3.ack_o != 2'b00) saw_ack = 1'b1;
    end
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (if3.ack_o != 2'b00) saw_ack = 1'b1;
    end
    chk("arst no ack", 32'(saw_ack), 32'd0);
    if3.addr1_i = 32'h60; if3.req_i = 2'b10;
    n = 0;
    do begin
      step();
      n++;
    end while (if3.ack_o == 2'b00 && n < 20);
    chk("post-rst latency", 32'(n), 32'd5);
    chk("post-rst ack", 32'(if3.ack_o), 32'h2);
    chk("post-rst rdata", if3.rdata_o, init_word(8'h60));
    if3.req_i = 2'b00;
    step();

`ifdef MEM_ARB_STATS_EN
    // Grant counters: 3 port-0 and 2 port-1 completions, then reset.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    txn1("st p0 a", 1'b0, 1'b0, 32'h10, 32'h0, 3);
    txn1("st p1 a", 1'b1, 1'b1, 32'h44, 32'h0000_0044, 2);
    txn1("st p0 b", 1'b0, 1'b1, 32'h48, 32'h0000_0048, 2);
    txn1("st p1 b", 1'b1, 1'b0, 32'h44, 32'h0, 3);
    txn1("st p0 c", 1'b0, 1'b0, 32'h48, 32'h0, 3);
    chk("stats cnt0", 32'(c1_0), 32'd3);
    chk("stats cnt1", 32'(c1_1), 32'd2);
    rst = 1'b0;
    #1;
    chk("stats cnt0 rst", 32'(c1_0), 32'd0);
    chk("stats cnt1 rst", 32'(c1_1), 32'd0);
    step();
    rst = 1'b1;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
